// File: rtl/hazard_stall_unit_if.sv
// Control-path bundle between the pipeline and the hazard/stall unit:
// ID/EX/MEM hazard sources and dmem handshake in, stall/flush controls and counters out.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             uses_rs1_ID;
  logic             uses_rs2_ID;
  logic             is_branch_ID;
  logic             branch_taken_ID;
  logic [4:0]       rd_EX;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic [4:0]       rd_MEM;
  logic             MemRead_MEM;
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             stall_IF;
  logic             stall_ID;
  logic             bubble_EX;
  logic             freeze;
  logic             flush_IF;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, is_branch_ID, branch_taken_ID,
           rd_EX, RegWrite_EX, MemRead_EX, rd_MEM, MemRead_MEM, dmem_req_MEM, dmem_ready,
    input  stall_IF, stall_ID, bubble_EX, freeze, flush_IF, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, is_branch_ID, branch_taken_ID,
           rd_EX, RegWrite_EX, MemRead_EX, rd_MEM, MemRead_MEM, dmem_req_MEM, dmem_ready,
    output stall_IF, stall_ID, bubble_EX, freeze, flush_IF, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Detects load-use, in-flight branch operand and dmem-wait hazards; drives stall,
// bubble, freeze and flush controls with a wait/timeout FSM and saturating counters.
module hazard_stall_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_unit_if.slave bus
);

  localparam int               WCW       = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]   TIMEOUT_V = WCW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  logic ex_match, mem_match, load_use, br_haz, haz, mem_wait;

  // x0 is never a real producer, so a zero rd can never match
  assign ex_match  = (bus.rd_EX != 5'd0) &&
                     ((bus.rd_EX == bus.rs1_ID && bus.uses_rs1_ID) ||
                      (bus.rd_EX == bus.rs2_ID && bus.uses_rs2_ID));
  assign mem_match = (bus.rd_MEM != 5'd0) &&
                     ((bus.rd_MEM == bus.rs1_ID && bus.uses_rs1_ID) ||
                      (bus.rd_MEM == bus.rs2_ID && bus.uses_rs2_ID));

  assign load_use = bus.MemRead_EX && ex_match;
  assign br_haz   = bus.is_branch_ID &&
                    ((bus.RegWrite_EX && ex_match) || (bus.MemRead_MEM && mem_match));
  assign haz      = load_use || br_haz;
  assign mem_wait = bus.dmem_req_MEM && !bus.dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      WAIT: begin
        if (bus.dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_V) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Freeze beats hazards, hazards beat the taken-branch flush
  always_comb begin
    bus.stall_IF  = 1'b0;
    bus.stall_ID  = 1'b0;
    bus.bubble_EX = 1'b0;
    bus.freeze    = 1'b0;
    bus.flush_IF  = 1'b0;
    if (rst_n) begin
      if (mem_wait || state_q == ERR) begin
        bus.freeze   = 1'b1;
        bus.stall_IF = 1'b1;
        bus.stall_ID = 1'b1;
      end else if (haz) begin
        bus.stall_IF  = 1'b1;
        bus.stall_ID  = 1'b1;
        bus.bubble_EX = 1'b1;
      end else if (bus.branch_taken_ID) begin
        bus.flush_IF = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (bus.stall_IF && stall_cycles_q != CNT_MAX)
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (bus.flush_IF && flush_count_q != CNT_MAX)
        flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign bus.mem_timeout  = (state_q == ERR);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit, built with TIMEOUT=8 and CNT_W=4
// so timeout and counter saturation are reachable in a few cycles.
module tb_hazard_stall_unit;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Expected bits: {stall_IF, stall_ID, bubble_EX, freeze, flush_IF}
  task automatic checkCtrl(input string tag, input logic [4:0] expected);
    checkOutput(tag, {27'b0, bus.stall_IF, bus.stall_ID, bus.bubble_EX, bus.freeze, bus.flush_IF},
                {27'b0, expected});
  endtask

  task automatic setIdle();
    bus.rs1_ID = 5'd0;  bus.rs2_ID = 5'd0;
    bus.uses_rs1_ID = 1'b0; bus.uses_rs2_ID = 1'b0;
    bus.is_branch_ID = 1'b0; bus.branch_taken_ID = 1'b0;
    bus.rd_EX = 5'd0; bus.RegWrite_EX = 1'b0; bus.MemRead_EX = 1'b0;
    bus.rd_MEM = 5'd0; bus.MemRead_MEM = 1'b0;
    bus.dmem_req_MEM = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic br, input logic tk,
                               input logic [4:0] rd_ex, input logic rw_ex, input logic mr_ex,
                               input logic [4:0] rd_mem, input logic mr_mem,
                               input logic req, input logic rdy);
    @(negedge clk);
    bus.rs1_ID = rs1; bus.rs2_ID = rs2;
    bus.uses_rs1_ID = u1; bus.uses_rs2_ID = u2;
    bus.is_branch_ID = br; bus.branch_taken_ID = tk;
    bus.rd_EX = rd_ex; bus.RegWrite_EX = rw_ex; bus.MemRead_EX = mr_ex;
    bus.rd_MEM = rd_mem; bus.MemRead_MEM = mr_mem;
    bus.dmem_req_MEM = req; bus.dmem_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    setIdle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with every hazard source active: outputs must still be zero
    setIdle();
    bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.rd_EX = 5'd5;
    bus.rs1_ID = 5'd5; bus.uses_rs1_ID = 1'b1;
    bus.branch_taken_ID = 1'b1; bus.dmem_req_MEM = 1'b1;
    #2;
    checkCtrl("reset_ctrl", 5'b00000);
    checkOutput("reset_timeout", 32'(bus.mem_timeout), 32'd0);
    checkOutput("reset_stall_cnt", 32'(bus.stall_cycles), 32'd0);
    checkOutput("reset_flush_cnt", 32'(bus.flush_count), 32'd0);
    resetDut();

    // Load-use: lw x5 in EX, add x?,x5 in ID
    applyStimulus(5'd5, 5'd6, 1, 1, 0, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0);
    checkCtrl("lu_stall", 5'b11100);
    step();
    applyStimulus(5'd5, 5'd6, 1, 1, 0, 0, 5'd0, 0, 0, 5'd5, 1, 0, 0);
    checkCtrl("lu_release", 5'b00000);
    step();
    checkOutput("lu_stall_cnt", 32'(bus.stall_cycles), 32'd1);

    // Branch after load: two stalls then a taken flush
    resetDut();
    applyStimulus(5'd7, 5'd0, 1, 1, 1, 1, 5'd7, 1, 1, 5'd0, 0, 0, 0);
    checkCtrl("br_ex_stall", 5'b11100);
    step();
    applyStimulus(5'd7, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 5'd7, 1, 0, 0);
    checkCtrl("br_mem_stall", 5'b11100);
    step();
    applyStimulus(5'd7, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    checkCtrl("br_flush", 5'b00001);
    step();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    checkCtrl("br_idle", 5'b00000);
    step();
    checkOutput("br_stall_cnt", 32'(bus.stall_cycles), 32'd2);
    checkOutput("br_flush_cnt", 32'(bus.flush_count), 32'd1);

    // x0 and unused operands never stall; ALU producer only matters for branches
    resetDut();
    applyStimulus(5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
    checkCtrl("x0_load", 5'b00000);
    applyStimulus(5'd1, 5'd3, 1, 0, 0, 0, 5'd3, 1, 1, 5'd0, 0, 0, 0);
    checkCtrl("unused_rs2", 5'b00000);
    applyStimulus(5'd1, 5'd4, 1, 1, 0, 0, 5'd4, 1, 0, 5'd0, 0, 0, 0);
    checkCtrl("alu_fwd_ok", 5'b00000);
    applyStimulus(5'd1, 5'd4, 1, 1, 1, 1, 5'd4, 1, 0, 5'd0, 0, 0, 0);
    checkCtrl("br_alu_stall", 5'b11100);
    step();
    checkOutput("mix_stall_cnt", 32'(bus.stall_cycles), 32'd1);

    // Memory wait freezes over taken branch and a load-use hazard
    resetDut();
    for (int i = 0; i < 4; i++) begin
      if (i == 2)
        applyStimulus(5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 1, 5'd0, 0, 1, 0);
      else
        applyStimulus(5'd1, 5'd2, 1, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
      checkCtrl($sformatf("wait_freeze_%0d", i), 5'b11010);
      step();
    end
    applyStimulus(5'd1, 5'd2, 1, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    checkCtrl("wait_ready_flush", 5'b00001);
    step();
    checkOutput("wait_timeout", 32'(bus.mem_timeout), 32'd0);
    checkOutput("wait_stall_cnt", 32'(bus.stall_cycles), 32'd4);
    checkOutput("wait_flush_cnt", 32'(bus.flush_count), 32'd1);

    // Timeout: WAIT counts to 8 then the next unready cycle enters ERR
    resetDut();
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      checkCtrl($sformatf("to_freeze_%0d", i), 5'b11010);
      checkOutput($sformatf("to_pending_%0d", i), 32'(bus.mem_timeout), 32'd0);
      step();
    end
    checkOutput("to_set", 32'(bus.mem_timeout), 32'd1);
    checkOutput("to_stall_cnt", 32'(bus.stall_cycles), 32'd9);
    applyStimulus(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    checkCtrl("err_freeze", 5'b11010);
    checkOutput("err_sticky", 32'(bus.mem_timeout), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkCtrl("err_async_rst_ctrl", 5'b00000);
    checkOutput("err_async_rst_to", 32'(bus.mem_timeout), 32'd0);
    checkOutput("err_async_rst_cnt", 32'(bus.stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkCtrl("post_err_run", 5'b00000);

    // Saturation: 20 stall cycles on a 4-bit counter
    resetDut();
    applyStimulus(5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step();
    checkOutput("sat_reach", 32'(bus.stall_cycles), 32'd15);
    for (int i = 0; i < 5; i++) step();
    checkOutput("sat_hold", 32'(bus.stall_cycles), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
